// File: rtl/nodf_mon_pkg.sv
// Package: nodf_mon_pkg
// Shared types and helpers for the non-dataflow upc loop performance monitor.
//   mod_state_e  : module handshake tracker states
//   loop_state_e : pipelined loop invocation tracker states
//   sat_inc      : saturating increment on a wide word, clamped at a caller-given maximum
//   Cnt*         : slot indices of the event counters inside the monitor's counter bank
package nodf_mon_pkg;

    typedef enum logic {M_IDLE, M_BUSY} mod_state_e;
    typedef enum logic {L_IDLE, L_RUN}  loop_state_e;

    // Widest counter supported; narrower counters zero-extend into this word.
    localparam int unsigned SatMaxW = 64;
    typedef logic [SatMaxW-1:0] sat_word_t;

    function automatic sat_word_t sat_inc(input sat_word_t val, input sat_word_t max_val);
        return (val >= max_val) ? max_val : val + sat_word_t'(1);
    endfunction

    localparam int unsigned NumCnt       = 9;
    localparam int unsigned CntModStart  = 0;
    localparam int unsigned CntModDone   = 1;
    localparam int unsigned CntModBusy   = 2;
    localparam int unsigned CntLoopInv   = 3;
    localparam int unsigned CntIterStart = 4;
    localparam int unsigned CntIterEnd   = 5;
    localparam int unsigned CntQuit      = 6;
    localparam int unsigned CntLoopCyc   = 7;
    localparam int unsigned CntLoopStall = 8;

endpackage

// File: rtl/sat_counter.sv
// Module: sat_counter
// Saturating event counter with synchronous clear and a freeze input.
//   clock  : posedge clock
//   clr    : synchronous clear, wins over everything
//   en     : count this cycle
//   freeze : hold the current value regardless of en
//   cnt    : counter value, sticks at all-ones
module sat_counter
    import nodf_mon_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             en,
    input  logic             freeze,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en && !freeze) begin
            cnt_d = CNT_W'(sat_inc(sat_word_t'(cnt_q), sat_word_t'(CntMax)));
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/nodf_upc_loop_monitor.sv
// Module: nodf_upc_loop_monitor
// Passive performance monitor for one HLS block and one pipelined upc loop inside it.
//   clock, reset (sync, active-high), finish (freezes counters)
//   ap_*          : module handshake probes
//   cur_state and *_state/_block/_enable : loop FSM probes and reference encodings
//   loop_*        : loop handshake probes, quit_at_end selects quit accounting
//   mod_*, loop_*, iter_*, quit_cnt, last_ii : registered statistics
//   frozen        : sticky once finish is seen; dump_valid pulses on that cycle
module nodf_upc_loop_monitor
    import nodf_mon_pkg::*;
#(
    parameter int unsigned STATE_W = 10,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               finish,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               quit_at_end,
    output logic               mod_busy,
    output logic [CNT_W-1:0]   mod_start_cnt,
    output logic [CNT_W-1:0]   mod_done_cnt,
    output logic [CNT_W-1:0]   mod_busy_cycles,
    output logic               loop_active,
    output logic [CNT_W-1:0]   loop_inv_cnt,
    output logic [CNT_W-1:0]   iter_start_cnt,
    output logic [CNT_W-1:0]   iter_end_cnt,
    output logic [CNT_W-1:0]   quit_cnt,
    output logic [CNT_W-1:0]   loop_cycles,
    output logic [CNT_W-1:0]   loop_stall_cycles,
    output logic [CNT_W-1:0]   last_ii,
    output logic               frozen,
    output logic               dump_valid
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic        at_istart, at_iend, mdone, istart, iend, iquit;
    logic        loop_accept, busy_cycle, stall, unused_loop_ready;
    mod_state_e  mod_state_d, mod_state_q;
    loop_state_e loop_state_d, loop_state_q;
    logic        frozen_d, frozen_q, dump_valid_d, dump_valid_q;
    logic        ii_first_d, ii_first_q;
    logic [CNT_W-1:0]  ii_cnt_d, ii_cnt_q, last_ii_d, last_ii_q;
    logic [NumCnt-1:0] cnt_en;
    logic [CNT_W-1:0]  cnt_val [NumCnt];

    // Probed only for completeness of the loop handshake; it carries no statistic.
    assign unused_loop_ready = loop_ready;

    assign at_istart = (cur_state == iter_start_state);
    assign at_iend   = (cur_state == iter_end_state);
    assign mdone     = ap_done & ap_continue;
    assign istart    = at_istart & iter_start_enable & ~iter_start_block;
    assign iend      = at_iend & iter_end_enable & ~iter_end_block;
    assign iquit     = (cur_state == quit_state) & quit_enable & ~quit_block;

    assign loop_accept = loop_start & (loop_state_q == L_IDLE);
    // The accepting cycle itself counts as busy, through the done cycle inclusive.
    assign busy_cycle  = (mod_state_q == M_BUSY) | ap_start;
    assign stall       = (loop_state_q == L_RUN) &
                         ((at_istart & iter_start_block) | (at_iend & iter_end_block));

    assign cnt_en[CntModStart]  = ap_start & ap_ready;
    assign cnt_en[CntModDone]   = mdone;
    assign cnt_en[CntModBusy]   = busy_cycle;
    assign cnt_en[CntLoopInv]   = loop_accept;
    assign cnt_en[CntIterStart] = istart;
    // Without quit_at_end an early quit closes the open iteration.
    assign cnt_en[CntIterEnd]   = iend | (iquit & ~quit_at_end);
    assign cnt_en[CntQuit]      = iquit;
    assign cnt_en[CntLoopCyc]   = (loop_state_q == L_RUN);
    assign cnt_en[CntLoopStall] = stall;

    for (genvar i = 0; i < NumCnt; i++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock  (clock),
            .clr    (reset),
            .en     (cnt_en[i]),
            .freeze (frozen_q),
            .cnt    (cnt_val[i])
        );
    end

    always_comb begin
        mod_state_d = mod_state_q;
        unique case (mod_state_q)
            M_IDLE: if (ap_start) mod_state_d = M_BUSY;
            M_BUSY: if (mdone && !ap_start) mod_state_d = M_IDLE;
        endcase
    end

    always_comb begin
        loop_state_d = loop_state_q;
        unique case (loop_state_q)
            L_IDLE: if (loop_start) loop_state_d = L_RUN;
            L_RUN:  if (loop_done && loop_continue) loop_state_d = L_IDLE;
        endcase
    end

    // Initiation interval: cycles since the previous istart of the same invocation.
    always_comb begin
        ii_cnt_d   = ii_cnt_q;
        last_ii_d  = last_ii_q;
        ii_first_d = ii_first_q;
        if (!frozen_q) begin
            if (istart) begin
                last_ii_d  = (ii_first_q || loop_accept) ? '0 : ii_cnt_q;
                ii_cnt_d   = CNT_W'(1);
                ii_first_d = 1'b0;
            end else begin
                ii_cnt_d = CNT_W'(sat_inc(sat_word_t'(ii_cnt_q), sat_word_t'(CntMax)));
                if (loop_accept) ii_first_d = 1'b1;
            end
        end
    end

    assign frozen_d     = frozen_q | finish;
    assign dump_valid_d = finish & ~frozen_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            mod_state_q  <= M_IDLE;
            loop_state_q <= L_IDLE;
            frozen_q     <= 1'b0;
            dump_valid_q <= 1'b0;
            ii_first_q   <= 1'b1;
            ii_cnt_q     <= '0;
            last_ii_q    <= '0;
        end else begin
            mod_state_q  <= mod_state_d;
            loop_state_q <= loop_state_d;
            frozen_q     <= frozen_d;
            dump_valid_q <= dump_valid_d;
            ii_first_q   <= ii_first_d;
            ii_cnt_q     <= ii_cnt_d;
            last_ii_q    <= last_ii_d;
        end
    end

    assign mod_busy          = (mod_state_q == M_BUSY);
    assign loop_active       = (loop_state_q == L_RUN);
    assign mod_start_cnt     = cnt_val[CntModStart];
    assign mod_done_cnt      = cnt_val[CntModDone];
    assign mod_busy_cycles   = cnt_val[CntModBusy];
    assign loop_inv_cnt      = cnt_val[CntLoopInv];
    assign iter_start_cnt    = cnt_val[CntIterStart];
    assign iter_end_cnt      = cnt_val[CntIterEnd];
    assign quit_cnt          = cnt_val[CntQuit];
    assign loop_cycles       = cnt_val[CntLoopCyc];
    assign loop_stall_cycles = cnt_val[CntLoopStall];
    assign last_ii           = last_ii_q;
    assign frozen            = frozen_q;
    assign dump_valid        = dump_valid_q;

endmodule

// File: tb/tb_nodf_upc_loop_monitor.sv
// Bench for nodf_upc_loop_monitor: two instances (32-bit and 4-bit counters) share stimulus.
// Each scenario ends with finish; the expected snapshot is queued and checked when dump_valid
// pulses, then counters are checked again after 20 further random cycles.
module tb_nodf_upc_loop_monitor;

    localparam int unsigned SW = 10;
    localparam logic [SW-1:0] ISS     = 10'b0000000100;
    localparam logic [SW-1:0] IES     = 10'b0001000000;
    localparam logic [SW-1:0] QS      = 10'b0100000000;
    localparam logic [SW-1:0] IDLE_ST = 10'b0000000001;
    localparam logic [SW-1:0] MID_ST  = 10'b0000001000;

    typedef struct packed {
        logic ap_start, ap_ready, ap_done, ap_continue;
        logic [SW-1:0] cur;
        logic isb, ieb, qb, ise, iee, qe;
        logic ls, ld, lc, qae, fin;
    } stim_t;

    typedef struct {
        longint mstart, mdn, mbc, inv, ist, ien, qct, lcy, lst, lii, busy, act;
    } exp_t;

    typedef struct {
        exp_t b;
        exp_t s;
    } sb_t;

    logic clock, reset, finish;
    logic ap_start, ap_ready, ap_done, ap_continue;
    logic [SW-1:0] cur_state;
    logic isb, ieb, qb, ise, iee, qe, ls, lr, ld, lc, qae;

    logic        mod_busy, loop_active, frozen, dump_valid;
    logic [31:0] mod_start_cnt, mod_done_cnt, mod_busy_cycles, loop_inv_cnt, iter_start_cnt;
    logic [31:0] iter_end_cnt, quit_cnt, loop_cycles, loop_stall_cycles, last_ii;
    logic        s_mod_busy, s_loop_active, s_frozen, s_dump_valid;
    logic [3:0]  s_mod_start_cnt, s_mod_done_cnt, s_mod_busy_cycles, s_loop_inv_cnt;
    logic [3:0]  s_iter_start_cnt, s_iter_end_cnt, s_quit_cnt, s_loop_cycles;
    logic [3:0]  s_loop_stall_cycles, s_last_ii;

    int    n_checks, n_errors, dump_cnt;
    string cur_name;
    stim_t sq[$];
    sb_t   sb_q[$];

    nodf_upc_loop_monitor #(.STATE_W(SW), .CNT_W(32)) u_dut (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .cur_state(cur_state), .iter_start_state(ISS), .iter_end_state(IES), .quit_state(QS),
        .iter_start_block(isb), .iter_end_block(ieb), .quit_block(qb),
        .iter_start_enable(ise), .iter_end_enable(iee), .quit_enable(qe),
        .loop_start(ls), .loop_ready(lr), .loop_done(ld), .loop_continue(lc),
        .quit_at_end(qae),
        .mod_busy(mod_busy), .mod_start_cnt(mod_start_cnt), .mod_done_cnt(mod_done_cnt),
        .mod_busy_cycles(mod_busy_cycles), .loop_active(loop_active),
        .loop_inv_cnt(loop_inv_cnt), .iter_start_cnt(iter_start_cnt),
        .iter_end_cnt(iter_end_cnt), .quit_cnt(quit_cnt), .loop_cycles(loop_cycles),
        .loop_stall_cycles(loop_stall_cycles), .last_ii(last_ii), .frozen(frozen),
        .dump_valid(dump_valid)
    );

    nodf_upc_loop_monitor #(.STATE_W(SW), .CNT_W(4)) u_small (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .cur_state(cur_state), .iter_start_state(ISS), .iter_end_state(IES), .quit_state(QS),
        .iter_start_block(isb), .iter_end_block(ieb), .quit_block(qb),
        .iter_start_enable(ise), .iter_end_enable(iee), .quit_enable(qe),
        .loop_start(ls), .loop_ready(lr), .loop_done(ld), .loop_continue(lc),
        .quit_at_end(qae),
        .mod_busy(s_mod_busy), .mod_start_cnt(s_mod_start_cnt), .mod_done_cnt(s_mod_done_cnt),
        .mod_busy_cycles(s_mod_busy_cycles), .loop_active(s_loop_active),
        .loop_inv_cnt(s_loop_inv_cnt), .iter_start_cnt(s_iter_start_cnt),
        .iter_end_cnt(s_iter_end_cnt), .quit_cnt(s_quit_cnt), .loop_cycles(s_loop_cycles),
        .loop_stall_cycles(s_loop_stall_cycles), .last_ii(s_last_ii), .frozen(s_frozen),
        .dump_valid(s_dump_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t b, input exp_t s, input bit hold);
        check({tag, ".mod_start_cnt"}, mod_start_cnt, b.mstart);
        check({tag, ".mod_done_cnt"}, mod_done_cnt, b.mdn);
        check({tag, ".mod_busy_cycles"}, mod_busy_cycles, b.mbc);
        check({tag, ".loop_inv_cnt"}, loop_inv_cnt, b.inv);
        check({tag, ".iter_start_cnt"}, iter_start_cnt, b.ist);
        check({tag, ".iter_end_cnt"}, iter_end_cnt, b.ien);
        check({tag, ".quit_cnt"}, quit_cnt, b.qct);
        check({tag, ".loop_cycles"}, loop_cycles, b.lcy);
        check({tag, ".loop_stall_cycles"}, loop_stall_cycles, b.lst);
        check({tag, ".last_ii"}, last_ii, b.lii);
        check({tag, ".s_mod_start_cnt"}, s_mod_start_cnt, s.mstart);
        check({tag, ".s_mod_done_cnt"}, s_mod_done_cnt, s.mdn);
        check({tag, ".s_mod_busy_cycles"}, s_mod_busy_cycles, s.mbc);
        check({tag, ".s_loop_inv_cnt"}, s_loop_inv_cnt, s.inv);
        check({tag, ".s_iter_start_cnt"}, s_iter_start_cnt, s.ist);
        check({tag, ".s_iter_end_cnt"}, s_iter_end_cnt, s.ien);
        check({tag, ".s_quit_cnt"}, s_quit_cnt, s.qct);
        check({tag, ".s_loop_cycles"}, s_loop_cycles, s.lcy);
        check({tag, ".s_loop_stall_cycles"}, s_loop_stall_cycles, s.lst);
        check({tag, ".s_last_ii"}, s_last_ii, s.lii);
        check({tag, ".frozen"}, frozen, 1);
        check({tag, ".s_frozen"}, s_frozen, 1);
        if (!hold) begin
            check({tag, ".mod_busy"}, mod_busy, b.busy);
            check({tag, ".loop_active"}, loop_active, b.act);
            check({tag, ".s_mod_busy"}, s_mod_busy, s.busy);
            check({tag, ".s_loop_active"}, s_loop_active, s.act);
        end
    endtask

    task automatic check_zero(input string tag);
        exp_t z;
        z = '{default: 0};
        check({tag, ".dump_valid"}, dump_valid, 0);
        check({tag, ".mod_busy"}, mod_busy, 0);
        check({tag, ".loop_active"}, loop_active, 0);
        check({tag, ".frozen"}, frozen, 0);
        check({tag, ".s_frozen"}, s_frozen, 0);
        // cmp with hold=1 also demands frozen=1, so compare counters individually here.
        check({tag, ".mod_start_cnt"}, mod_start_cnt, z.mstart);
        check({tag, ".mod_done_cnt"}, mod_done_cnt, z.mdn);
        check({tag, ".mod_busy_cycles"}, mod_busy_cycles, z.mbc);
        check({tag, ".loop_inv_cnt"}, loop_inv_cnt, z.inv);
        check({tag, ".iter_start_cnt"}, iter_start_cnt, z.ist);
        check({tag, ".iter_end_cnt"}, iter_end_cnt, z.ien);
        check({tag, ".quit_cnt"}, quit_cnt, z.qct);
        check({tag, ".loop_cycles"}, loop_cycles, z.lcy);
        check({tag, ".loop_stall_cycles"}, loop_stall_cycles, z.lst);
        check({tag, ".last_ii"}, last_ii, z.lii);
        check({tag, ".s_iter_start_cnt"}, s_iter_start_cnt, z.ist);
        check({tag, ".s_loop_cycles"}, s_loop_cycles, z.lcy);
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        s.cur = IDLE_ST;
        s.qae = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim(input bit qae_v);
        stim_t s;
        s = idle_stim();
        s.ap_start    = ($urandom_range(3) == 0);
        s.ap_ready    = ($urandom_range(1) == 0);
        s.ap_done     = ($urandom_range(3) == 0);
        s.ap_continue = ($urandom_range(2) != 0);
        case ($urandom_range(4))
            0:       s.cur = ISS;
            1:       s.cur = IES;
            2:       s.cur = QS;
            3:       s.cur = MID_ST;
            default: s.cur = IDLE_ST;
        endcase
        s.isb = ($urandom_range(2) == 0);
        s.ieb = ($urandom_range(2) == 0);
        s.qb  = ($urandom_range(2) == 0);
        s.ise = ($urandom_range(3) != 0);
        s.iee = ($urandom_range(3) != 0);
        s.qe  = ($urandom_range(1) == 0);
        s.ls  = ($urandom_range(5) == 0);
        s.ld  = ($urandom_range(5) == 0);
        s.lc  = ($urandom_range(1) == 0);
        s.qae = qae_v;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        ap_start = s.ap_start; ap_ready = s.ap_ready;
        ap_done = s.ap_done; ap_continue = s.ap_continue;
        cur_state = s.cur;
        isb = s.isb; ieb = s.ieb; qb = s.qb; ise = s.ise; iee = s.iee; qe = s.qe;
        ls = s.ls; lr = s.ls; ld = s.ld; lc = s.lc; qae = s.qae; finish = s.fin;
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: scans the queued cycles up to and including the first finish cycle.
    function automatic exp_t model(input int unsigned w);
        exp_t   e;
        longint mx, ms, md, bc, inv, ist, ien, qc, lcy, lst, lii;
        longint prev;
        bit     busy, run, mdone, istart, iend, iquit, accept;
        stim_t  s;
        mx = (longint'(1) << w) - 1;
        ms = 0; md = 0; bc = 0; inv = 0; ist = 0; ien = 0; qc = 0; lcy = 0; lst = 0; lii = 0;
        prev = -1; busy = 0; run = 0;
        for (int k = 0; k < sq.size(); k++) begin
            s = sq[k];
            mdone = s.ap_done && s.ap_continue;
            if (s.ap_start && s.ap_ready) ms++;
            if (mdone) md++;
            if (busy) begin
                bc++;
                if (mdone && !s.ap_start) busy = 0;
            end else if (s.ap_start) begin
                bc++;
                busy = 1;
            end
            istart = (s.cur == ISS) && s.ise && !s.isb;
            iend   = (s.cur == IES) && s.iee && !s.ieb;
            iquit  = (s.cur == QS) && s.qe && !s.qb;
            accept = s.ls && !run;
            if (run) lcy++;
            if (run && (((s.cur == ISS) && s.isb) || ((s.cur == IES) && s.ieb))) lst++;
            if (accept) begin
                inv++;
                prev = -1;
            end
            if (istart) begin
                ist++;
                lii  = (prev < 0) ? 0 : sat(longint'(k) - prev, mx);
                prev = k;
            end
            if (iend || (!s.qae && iquit)) ien++;
            if (iquit) qc++;
            if (accept) run = 1;
            else if (run && s.ld && s.lc) run = 0;
            if (s.fin) break;
        end
        e.mstart = sat(ms, mx); e.mdn = sat(md, mx); e.mbc = sat(bc, mx);
        e.inv = sat(inv, mx); e.ist = sat(ist, mx); e.ien = sat(ien, mx);
        e.qct = sat(qc, mx); e.lcy = sat(lcy, mx); e.lst = sat(lst, mx); e.lii = lii;
        e.busy = busy; e.act = run;
        return e;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        drive(idle_stim());
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic add_loop(input int n_iter, input bit qae_v);
        stim_t s;
        s = idle_stim(); s.qae = qae_v; s.ls = 1'b1;
        sq.push_back(s);
        for (int it = 0; it < n_iter; it++) begin
            for (int j = 0; j < 5; j++) begin
                s = idle_stim(); s.qae = qae_v;
                if (j == 0) begin s.cur = ISS; s.ise = 1'b1; end
                else if (j == 2) begin s.cur = IES; s.iee = 1'b1; end
                else s.cur = MID_ST;
                sq.push_back(s);
            end
        end
    endtask

    task automatic run_scenario(input string name);
        sb_t   x;
        stim_t s;
        int    dump_base;
        sq[sq.size()-1].fin = 1'b1;
        cur_name = name;
        do_reset();
        check_zero({name, ".after_reset"});
        x.b = model(32);
        x.s = model(4);
        sb_q.push_back(x);
        dump_base = dump_cnt;
        foreach (sq[i]) begin
            drive(sq[i]);
            @(posedge clock);
            #1;
        end
        drive(idle_stim());
        for (int i = 0; i < 5 && sb_q.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s.dump_timeout: got no dump_valid expected one within 5 cycles", name);
            sb_q.delete();
        end
        for (int i = 0; i < 20; i++) begin
            s = rand_stim($urandom_range(1) == 0);
            s.fin = ($urandom_range(2) == 0);
            drive(s);
            @(posedge clock);
            #1;
        end
        drive(idle_stim());
        cmp({name, ".hold"}, x.b, x.s, 1'b1);
        check({name, ".dump_pulses"}, dump_cnt - dump_base, 1);
    endtask

    // Monitor: compare the queued snapshot whenever the DUT presents its dump.
    always @(negedge clock) begin
        sb_t x;
        if (!reset && dump_valid) begin
            dump_cnt++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s.unexpected_dump: got dump_valid=1 expected 0", cur_name);
            end else begin
                x = sb_q.pop_front();
                check({cur_name, ".s_dump_valid"}, s_dump_valid, 1);
                cmp({cur_name, ".dump"}, x.b, x.s, 1'b0);
            end
        end
    end

    initial begin
        stim_t s;
        bit    q;
        n_checks = 0;
        n_errors = 0;
        dump_cnt = 0;
        cur_name = "init";
        reset = 1'b1;
        drive(idle_stim());

        sq.delete();
        sq.push_back(idle_stim());
        run_scenario("reset_only");

        sq.delete();
        sq.push_back(idle_stim());
        s = idle_stim(); s.ap_start = 1'b1; s.ap_ready = 1'b1; sq.push_back(s);
        repeat (4) sq.push_back(idle_stim());
        s = idle_stim(); s.ap_done = 1'b1; s.ap_continue = 1'b1; sq.push_back(s);
        repeat (2) sq.push_back(idle_stim());
        run_scenario("single_call");

        sq.delete();
        add_loop(4, 1'b1);
        run_scenario("loop4");

        sq.delete();
        s = idle_stim(); s.ls = 1'b1; sq.push_back(s);
        s = idle_stim(); s.cur = ISS; s.ise = 1'b1; s.isb = 1'b1;
        repeat (3) sq.push_back(s);
        s.isb = 1'b0; sq.push_back(s);
        s = idle_stim(); s.cur = MID_ST; sq.push_back(s);
        s = idle_stim(); s.cur = IES; s.iee = 1'b1; sq.push_back(s);
        run_scenario("stall");

        sq.delete();
        s = idle_stim(); s.qae = 1'b0; s.ls = 1'b1; sq.push_back(s);
        s = idle_stim(); s.qae = 1'b0; s.cur = ISS; s.ise = 1'b1; sq.push_back(s);
        s = idle_stim(); s.qae = 1'b0; s.cur = MID_ST; sq.push_back(s);
        s = idle_stim(); s.qae = 1'b0; s.cur = IES; s.iee = 1'b1; sq.push_back(s);
        s = idle_stim(); s.qae = 1'b0; s.cur = MID_ST; sq.push_back(s);
        s = idle_stim(); s.qae = 1'b0; s.cur = ISS; s.ise = 1'b1; sq.push_back(s);
        s = idle_stim(); s.qae = 1'b0; s.cur = MID_ST; sq.push_back(s);
        s = idle_stim(); s.qae = 1'b0; s.cur = QS; s.qe = 1'b1; sq.push_back(s);
        s = idle_stim(); s.qae = 1'b0; s.ld = 1'b1; s.lc = 1'b1; sq.push_back(s);
        run_scenario("quit_early");

        sq.delete();
        add_loop(20, 1'b1);
        run_scenario("loop20");

        for (int r = 0; r < 4; r++) begin
            sq.delete();
            q = ($urandom_range(1) == 0);
            for (int i = 0; i < 60; i++) sq.push_back(rand_stim(q));
            run_scenario($sformatf("random%0d", r));
        end

        cur_name = "midrun_reset";
        do_reset();
        for (int i = 0; i < 30; i++) begin
            drive(rand_stim(1'b0));
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        drive(rand_stim(1'b1));
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(idle_stim());
        check_zero("midrun_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
